// File: rtl/uart_rx_ascii.sv
// uart_rx_ascii
//   8N1 UART receiver that presents each good byte as a held ASCII code for
//   the downstream 7-segment decoder.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx          asynchronous serial line, idle high
//   ascii_code  last correctly received byte, held between updates
//   ascii_valid one-cycle pulse in the cycle ascii_code takes a new value
//   frame_err   one-cycle pulse when the stop bit is sampled low
//   busy        high whenever the receiver is not idle
module uart_rx_ascii #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  RESET_CODE   = 8'h30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] ascii_code,
    output logic       ascii_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rxState_t;

    rxState_t      state, stateNext;
    logic          rxMeta, rxs;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic [7:0]    shiftReg, shiftNext;
    logic [7:0]    codeNext;
    logic          validNext, errNext;

    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // never fabricates a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxMeta <= rx;
            rxs    <= rxMeta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            bitIdx      <= '0;
            shiftReg    <= '0;
            ascii_code  <= RESET_CODE;
            ascii_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= stateNext;
            cnt         <= cntNext;
            bitIdx      <= bitIdxNext;
            shiftReg    <= shiftNext;
            ascii_code  <= codeNext;
            ascii_valid <= validNext;
            frame_err   <= errNext;
        end
    end

    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bitIdxNext = bitIdx;
        shiftNext  = shiftReg;
        codeNext   = ascii_code;
        validNext  = 1'b0;
        errNext    = 1'b0;

        unique case (state)
            IDLE: begin
                if (!rxs) begin
                    stateNext = START;
                    cntNext   = '0;
                end
            end

            // Re-check the line half a bit in: a low that has gone away by
            // then was a glitch and is dropped silently.
            START: begin
                if (cnt == HALF) begin
                    cntNext    = '0;
                    bitIdxNext = '0;
                    stateNext  = rxs ? IDLE : DATA;
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end

            // Counter is now phased to mid-bit; every full period lands on
            // the centre of the next data bit. Shifting in at the MSB leaves
            // the first (LSB) bit in bit 0 after eight samples.
            DATA: begin
                if (cnt == LAST) begin
                    cntNext   = '0;
                    shiftNext = {rxs, shiftReg[7:1]};
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end

            // Decision at mid-stop returns to IDLE half a bit early, which
            // leaves room to catch a back-to-back start edge.
            STOP: begin
                if (cnt == LAST) begin
                    cntNext = '0;
                    if (rxs) begin
                        codeNext  = shiftReg;
                        validNext = 1'b1;
                        stateNext = IDLE;
                    end else begin
                        errNext   = 1'b1;
                        stateNext = BRK;
                    end
                end else begin
                    cntNext = cnt + CW'(1);
                end
            end

            // Line held low after a bad stop bit (break); wait for it to
            // recover so the low level is never taken as a new start bit.
            BRK: begin
                if (rxs) begin
                    stateNext = IDLE;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ascii.sv
module tb_uart_rx_ascii;

    localparam int CPB = 16;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] ascii_code;
    logic       ascii_valid;
    logic       frame_err;
    logic       busy;

    uart_rx_ascii #(.CLKS_PER_BIT(CPB), .RESET_CODE(8'h30)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .ascii_code (ascii_code),
        .ascii_valid(ascii_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor: counts pulses, logs received codes, flags illegal overlaps
    // and any code change outside a valid pulse.
    int         validCnt  = 0;
    int         errCnt    = 0;
    int         overlap   = 0;
    int         badChange = 0;
    int         busyHigh  = 0;
    logic [7:0] codeQ[$];
    logic [7:0] prevCode  = 8'h30;
    logic       prevRstn  = 1'b0;

    always @(negedge clk) begin
        if (ascii_valid) begin
            validCnt++;
            codeQ.push_back(ascii_code);
        end
        if (frame_err) errCnt++;
        if (ascii_valid && frame_err) overlap++;
        if (busy) busyHigh++;
        if (rst_n && prevRstn && !ascii_valid && ascii_code !== prevCode) badChange++;
        prevCode = ascii_code;
        prevRstn = rst_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bitOut(input logic v);
        #1 rx = v;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic idle(input int n);
        #1 rx = 1'b1;
        repeat (n) @(posedge clk);
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic stopBit);
        bitOut(1'b0);
        for (int i = 0; i < 8; i++) bitOut(d[i]);
        bitOut(stopBit);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stopOk;
        int         expValid;
        int         expErr;
        logic [7:0] expCode;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int v0, e0, b0;
        logic [7:0] c0;

        vecs[0] = '{8'h35, 1'b1, 1, 0, 8'h35};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[4] = '{8'h41, 1'b0, 0, 1, 8'hA5};
        vecs[5] = '{8'h32, 1'b1, 1, 0, 8'h32};

        // Reset state
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code",  ascii_code,  8'h30);
        chk("rst_valid", ascii_valid, 1'b0);
        chk("rst_err",   frame_err,   1'b0);
        chk("rst_busy",  busy,        1'b0);
        rst_n = 1'b1;
        v0 = validCnt; e0 = errCnt; b0 = busyHigh;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_code",   ascii_code,      8'h30);
        chk("idle_valid",  validCnt - v0,   0);
        chk("idle_err",    errCnt - e0,     0);
        chk("idle_busy",   busyHigh - b0,   0);

        // Table-driven frames (single byte, extremes, framing error, recovery)
        for (int k = 0; k < 6; k++) begin
            v0 = validCnt; e0 = errCnt;
            sendFrame(vecs[k].data, vecs[k].stopOk);
            if (!vecs[k].stopOk) begin
                repeat (40) @(posedge clk);
                #1;
                chk($sformatf("v%0d_busy_break", k), busy, 1'b1);
                idle(2 * CPB);
            end else begin
                idle(CPB);
            end
            #1;
            chk($sformatf("v%0d_valid", k), validCnt - v0, vecs[k].expValid);
            chk($sformatf("v%0d_err", k),   errCnt - e0,   vecs[k].expErr);
            chk($sformatf("v%0d_code", k),  ascii_code,    vecs[k].expCode);
            chk($sformatf("v%0d_busy", k),  busy,          1'b0);
        end

        // Back-to-back '0'..'9' with no idle gap
        codeQ.delete();
        e0 = errCnt;
        for (int k = 0; k < 10; k++) sendFrame(8'h30 + 8'(k), 1'b1);
        idle(CPB);
        chk("b2b_count", codeQ.size(), 10);
        chk("b2b_err",   errCnt - e0,  0);
        for (int k = 0; k < 10; k++) begin
            if (k < codeQ.size()) chk($sformatf("b2b_code%0d", k), codeQ[k], 8'h30 + 8'(k));
        end

        // Glitch: 5-cycle low pulse is rejected
        v0 = validCnt; e0 = errCnt; c0 = ascii_code;
        #1 rx = 1'b0;
        repeat (5) @(posedge clk);
        #1 rx = 1'b1;
        #1;
        chk("glitch_busy_hi", busy, 1'b1);
        repeat (7) @(posedge clk);  // 12 edges after the pulse: 2 sync + HALF+3
        #1;
        chk("glitch_busy_lo", busy, 1'b0);
        idle(CPB);
        chk("glitch_valid", validCnt - v0, 0);
        chk("glitch_err",   errCnt - e0,   0);
        chk("glitch_code",  ascii_code,    c0);

        // Reset mid-frame after 4 data bits of '7'
        v0 = validCnt; e0 = errCnt;
        bitOut(1'b0);
        for (int i = 0; i < 4; i++) bitOut(vecs[0].data[i] ^ 1'b0 ? 1'b1 : (8'h37 >> i) & 8'h01 ? 1'b1 : 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_code",  ascii_code,  8'h30);
        chk("mid_rst_busy",  busy,        1'b0);
        chk("mid_rst_valid", ascii_valid, 1'b0);
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(CPB);
        chk("mid_rst_nopulse", validCnt - v0, 0);
        sendFrame(8'h38, 1'b1);
        idle(CPB);
        chk("after_rst_code",  ascii_code,    8'h38);
        chk("after_rst_valid", validCnt - v0, 1);
        chk("after_rst_err",   errCnt - e0,   0);

        // Global invariants over the whole run
        chk("no_overlap",    overlap,   0);
        chk("code_held",     badChange, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ascii.md
Name: uart_rx_ascii

Overview:
- Serial receiver directly upstream of the ASCII-to-7-segment decoder.
- Deserialises 8N1 UART frames from an external terminal and presents each received byte as a held 8-bit ASCII code. The decoder consumes that code to drive a digit.
- Also pulses a strobe on each good byte and flags framing errors.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range 8..65535
RESET_CODE, 8'h30, value of ascii_code after reset (ASCII '0', so the display shows 0)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
rx  input  1  asynchronous serial line, idle high
ascii_code  output  8  last correctly received byte, held stable between updates; feeds decoder AsciiCode
ascii_valid  output  1  one-cycle pulse when ascii_code is updated
frame_err  output  1  one-cycle pulse when the stop bit is sampled low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (rst_n=0, asynchronous):
  - ascii_code=RESET_CODE, ascii_valid=0, frame_err=0, busy=0.
  - FSM=IDLE; synchroniser flops=1; counters and shift register=0.
- Synchroniser: rx passes through 2 flops; all decisions use the synced value rxs (2-cycle pin-to-FSM delay).
- HALF = (CLKS_PER_BIT-1)/2, integer division.
- Bit counter: width ceil(log2(CLKS_PER_BIT)). Bit index: 3 bits.
- FSM states:
  - IDLE: if rxs=0, go to START and clear the counter.
  - START:
    - Counter increments each cycle.
    - When counter==HALF: if rxs=0, go to DATA with counter=0 and index=0.
    - Otherwise (glitch shorter than half a bit), return to IDLE with no output pulse.
  - DATA:
    - When counter==CLKS_PER_BIT-1: shift rxs into the shift register LSB-first (bit index i lands in bit i) and clear the counter.
    - After index 7 is sampled, go to STOP. Otherwise increment the index.
  - STOP: when counter==CLKS_PER_BIT-1, sample rxs.
    - rxs=1: ascii_code<=shift register; ascii_valid=1 for the next cycle only; go to IDLE.
    - rxs=0: frame_err=1 for one cycle; ascii_code unchanged; go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. A low line must never start a new frame.
- Latency: ascii_valid rises between 9.5 and 10 bit periods (plus up to 3 clk) after the rx falling edge of the start bit.
- ascii_code changes only in the cycle ascii_valid is high. It is never partially updated.
- busy=1 in START, DATA, STOP and BREAK. busy=0 in IDLE.
- Back-to-back frames: a start bit arriving immediately after a good stop bit is detected. The FSM is back in IDLE before the mid-stop sample plus half a bit elapses, so there is no dead time.
- Any byte value 0x00..0xFF is accepted. Filtering of non-digit codes is the consumer's responsibility.
- rst_n asserted mid-frame: everything returns to reset values immediately and the partial byte is discarded. After release, the FSM waits in IDLE for a falling rxs edge. If rx is already low at release, it enters START and is then validated normally.
- ascii_valid and frame_err are never high in the same cycle.

Test Plan:
All scenarios use CLKS_PER_BIT=16.
- Reset: hold rst_n=0 with rx=1 -> ascii_code=8'h30, ascii_valid=0, frame_err=0, busy=0. Release -> outputs unchanged for 100 cycles.
- Single byte: send 8'h35 ('5') in 8N1 -> exactly one ascii_valid pulse, ascii_code=8'h35, frame_err never high, busy falls to 0 after the stop bit.
- Back-to-back: send 8'h30..8'h39 with no idle gap -> ten ascii_valid pulses with ascii_code 30,31,...,39 in order, and no frame_err.
- Glitch: pulse rx low for 5 cycles -> returns to IDLE by cycle HALF+3, no ascii_valid, no frame_err, ascii_code unchanged.
- Framing error: send 8'h41 with the stop bit low and rx held low for 40 more cycles -> one frame_err pulse, no ascii_valid, ascii_code keeps its previous value, busy=1 until rx goes high. A following good 8'h32 is then received correctly.
- Reset mid-frame: assert rst_n after 4 data bits of 8'h37 -> ascii_code=8'h30 immediately, no pulse. The next full frame 8'h38 is received correctly.
